// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that shares the single register-file
// write port between N_REQ writeback sources. Every output is registered.
// Optional build macro R0_WRITE_BLOCK_EN: a grant whose index is 0 still
// releases the requester, but it suppresses wr_en and pulses r0_drop instead.
module reg_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*IDX_W-1:0]    req_idx,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      stall,
  output logic [N_REQ-1:0]          gnt,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
`ifdef R0_WRITE_BLOCK_EN
  ,
  output logic                      r0_drop
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               wr_en_q, wr_en_d;
  logic [IDX_W-1:0]   wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
`ifdef R0_WRITE_BLOCK_EN
  logic               r0_drop_q, r0_drop_d;
`endif

  logic [N_REQ-1:0]   eligible_s;
  logic [PTR_W:0]     pick_s;
  logic               grant_s;
  logic [PTR_W-1:0]   win_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [DATA_W-1:0]  win_data_s;

  // First set bit of elig searching upward from start, wrapping modulo N_REQ.
  // Result MSB flags that a winner was found; low bits carry its number.
  function automatic logic [PTR_W:0] pick_first(input logic [N_REQ-1:0] elig,
                                                input logic [PTR_W-1:0] start);
    logic [PTR_W:0] res;
    int             cand;
    res = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(start) + i) % N_REQ;
      if (!res[PTR_W] && elig[cand]) begin
        res = {1'b1, PTR_W'(cand)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration: the requester granted last cycle is masked out for one cycle.
  always_comb begin
    eligible_s = req & ~gnt_q;
    pick_s     = pick_first(eligible_s, ptr_q);
    grant_s    = !stall && pick_s[PTR_W];
    win_s      = pick_s[PTR_W-1:0];
    win_idx_s  = req_idx[win_s*IDX_W +: IDX_W];
    win_data_s = req_data[win_s*DATA_W +: DATA_W];
  end

  // State register and all registered outputs, synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
`ifdef R0_WRITE_BLOCK_EN
      r0_drop_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
`ifdef R0_WRITE_BLOCK_EN
      r0_drop_q <= r0_drop_d;
`endif
    end
  end

  // Next state: any issued grant lands in ISSUE; otherwise return to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (grant_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and pointer values loaded at the next edge; index/data hold when idle.
  always_comb begin
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    ptr_d     = ptr_q;
`ifdef R0_WRITE_BLOCK_EN
    r0_drop_d = 1'b0;
`endif
    if (grant_s) begin
      gnt_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
      wr_sel_d  = win_idx_s;
      wr_data_d = win_data_s;
      busy_d    = 1'b1;
      if (win_s == PTR_W'(N_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_s + PTR_W'(1);
      end
`ifdef R0_WRITE_BLOCK_EN
      if (win_idx_s == '0) begin
        wr_en_d   = 1'b0;
        r0_drop_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        r0_drop_d = 1'b0;
      end
`else
      wr_en_d = 1'b1;
`endif
    end else begin
      gnt_d   = '0;
      wr_en_d = 1'b0;
    end
  end

  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
`ifdef R0_WRITE_BLOCK_EN
  assign r0_drop = r0_drop_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with hand-computed expectations.
module tb_reg_write_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  logic                    clock = 1'b0;
  logic                    clear;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*IDX_W-1:0]  req_idx;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    stall;
  logic [N_REQ-1:0]        gnt;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_sel;
  logic [DATA_W-1:0]       wr_data;
  logic                    busy;
`ifdef R0_WRITE_BLOCK_EN
  logic                    r0_drop;
`endif

  int err_cnt   = 0;
  int check_cnt = 0;

  reg_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock    (clock),
    .clear    (clear),
    .req      (req),
    .req_idx  (req_idx),
    .req_data (req_data),
    .stall    (stall),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .busy     (busy)
`ifdef R0_WRITE_BLOCK_EN
    ,
    .r0_drop  (r0_drop)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [IDX_W-1:0] sel, input logic [DATA_W-1:0] data);
    check_eq({tag, ".gnt"},   64'(gnt),     64'(3'b000));
    check_eq({tag, ".wr_en"}, 64'(wr_en),   64'(1'b0));
    check_eq({tag, ".sel"},   64'(wr_sel),  64'(sel));
    check_eq({tag, ".data"},  64'(wr_data), 64'(data));
    check_eq({tag, ".busy"},  64'(busy),    64'(1'b0));
  endtask

  task automatic check_write(input string tag, input logic [N_REQ-1:0] g,
                             input logic [IDX_W-1:0] sel, input logic [DATA_W-1:0] data);
    check_eq({tag, ".gnt"},   64'(gnt),     64'(g));
    check_eq({tag, ".wr_en"}, 64'(wr_en),   64'(1'b1));
    check_eq({tag, ".sel"},   64'(wr_sel),  64'(sel));
    check_eq({tag, ".data"},  64'(wr_data), 64'(data));
    check_eq({tag, ".busy"},  64'(busy),    64'(1'b1));
  endtask

  initial begin
    clear    = 1'b1;
    stall    = 1'b0;
    req      = 3'b111;
    req_idx  = {4'd9, 4'd5, 4'd3};
    req_data = {32'hCAFE_0002, 32'hDEAD_BEEF, 32'h1111_0000};

    // reset held two cycles with all requests up
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("reset", 4'd0, 32'h0);
    end
    clear = 1'b0;

    // first grant after reset goes to requester 0
    tick();
    check_write("first", 3'b001, 4'd3, 32'h1111_0000);
    req = 3'b000;
    tick();
    check_idle("first_end", 4'd3, 32'h1111_0000);

    // single request from requester 1 (ptr now 1)
    req = 3'b010;
    tick();
    check_write("single", 3'b010, 4'd5, 32'hDEAD_BEEF);
    req = 3'b000;
    tick();
    check_idle("single_end", 4'd5, 32'hDEAD_BEEF);

    // bring ptr back to 0 via requester 2
    req = 3'b100;
    tick();
    check_write("r2", 3'b100, 4'd9, 32'hCAFE_0002);
    req = 3'b000;
    tick();
    check_idle("r2_end", 4'd9, 32'hCAFE_0002);

    // round robin with all requests held: 001,010,100,001 back to back
    req = 3'b111;
    tick();
    check_write("rr0", 3'b001, 4'd3, 32'h1111_0000);
    tick();
    check_write("rr1", 3'b010, 4'd5, 32'hDEAD_BEEF);
    tick();
    check_write("rr2", 3'b100, 4'd9, 32'hCAFE_0002);
    tick();
    check_write("rr3", 3'b001, 4'd3, 32'h1111_0000);

    // next grant (ptr=1) then clear during the write
    tick();
    check_write("pre_clr", 3'b010, 4'd5, 32'hDEAD_BEEF);
    clear = 1'b1;
    tick();
    check_idle("mid_clr", 4'd0, 32'h0);
    clear = 1'b0;

    // stall for three cycles with req=101: nothing granted
    req   = 3'b101;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("stall", 4'd0, 32'h0);
    end
    stall = 1'b0;
    tick();
    check_write("unstall0", 3'b001, 4'd3, 32'h1111_0000);
    req = 3'b100;
    tick();
    check_write("unstall2", 3'b100, 4'd9, 32'hCAFE_0002);
    req = 3'b000;
    tick();
    check_idle("unstall_end", 4'd9, 32'hCAFE_0002);

    // stall raised during a write: the write still ends after one cycle
    req = 3'b011;
    tick();
    check_write("sw0", 3'b001, 4'd3, 32'h1111_0000);
    req   = 3'b010;
    stall = 1'b1;
    tick();
    check_idle("sw_stall", 4'd3, 32'h1111_0000);
    stall = 1'b0;
    tick();
    check_write("sw1", 3'b010, 4'd5, 32'hDEAD_BEEF);
    req = 3'b000;
    tick();
    check_idle("sw_end", 4'd5, 32'hDEAD_BEEF);

    // request dropped before it could be granted
    req   = 3'b001;
    stall = 1'b1;
    tick();
    check_idle("drop_a", 4'd5, 32'hDEAD_BEEF);
    req   = 3'b000;
    stall = 1'b0;
    tick();
    check_idle("drop_b", 4'd5, 32'hDEAD_BEEF);

    // write to register 0 from requester 0 (ptr=2, wraps to 0)
    req_idx = {4'd9, 4'd5, 4'd0};
    req     = 3'b001;
    tick();
    check_eq("r0.gnt",  64'(gnt),     64'(3'b001));
    check_eq("r0.sel",  64'(wr_sel),  64'(4'd0));
    check_eq("r0.data", 64'(wr_data), 64'(32'h1111_0000));
`ifdef R0_WRITE_BLOCK_EN
    check_eq("r0.wr_en",   64'(wr_en),   64'(1'b0));
    check_eq("r0.r0_drop", 64'(r0_drop), 64'(1'b1));
`else
    check_eq("r0.wr_en",   64'(wr_en),   64'(1'b1));
`endif
    req = 3'b000;
    tick();
    check_eq("r0_end.wr_en", 64'(wr_en), 64'(1'b0));
    check_eq("r0_end.gnt",   64'(gnt),   64'(3'b000));
`ifdef R0_WRITE_BLOCK_EN
    check_eq("r0_end.r0_drop", 64'(r0_drop), 64'(1'b0));
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port between N_REQ writeback sources (ALU result, memory load, in-port).
- Round-robin arbitration with a req/gnt handshake.
- Drives a 4-bit register index (wr_sel) into the 4-to-16 select decoder, plus a qualifying write enable and the write data.
- Sits between the execute/memory stages and the register file.

Parameters:
N_REQ, 3, number of requesters (2..8)
DATA_W, 32, write data width
IDX_W, 4, register index width (feeds 16-register decoder)

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  synchronous active-high reset
req  in  N_REQ  per-requester write request, held until granted
req_idx  in  N_REQ*IDX_W  packed register index, requester i at bits [i*IDX_W +: IDX_W]
req_data  in  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
stall  in  1  freeze arbitration; no new grant issued while high
gnt  out  N_REQ  one-hot grant pulse, one cycle per accepted request
wr_en  out  1  register-file write strobe
wr_sel  out  IDX_W  register index to select decoder
wr_data  out  DATA_W  write data to register file
busy  out  1  high in ISSUE state

Behaviour:
- Reset (clear=1 at clock edge): state=IDLE, gnt=0, wr_en=0, wr_sel=0, wr_data=0, busy=0, round-robin pointer ptr=0.
- All outputs registered.
- States: IDLE, ISSUE.
- IDLE:
  - If stall=0 and req has any bit set, choose the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Next edge: gnt[w]=1, wr_en=1, wr_sel=req_idx[w], wr_data=req_data[w], busy=1, ptr=(w+1) mod N_REQ, state→ISSUE.
- ISSUE:
  - Lasts exactly one cycle; gnt and wr_en are single-cycle pulses.
  - Next edge: gnt=0, wr_en=0, busy=0. wr_sel and wr_data hold their last values.
  - If stall=0 and any request other than the one just granted is pending, grant it directly in this same transition and stay in ISSUE (back-to-back writes). Otherwise go to IDLE.
- Latency: req rising in IDLE to wr_en = 1 cycle. Sustained throughput: 1 write per cycle while requests are pending.
- Handshake:
  - A requester deasserts req on the cycle after it sees gnt.
  - The arbiter never grants the same requester on two consecutive cycles. Its req is ignored for one cycle after its gnt.
- Fairness: a continuously requesting source waits at most N_REQ-1 grants.
- Stall: while stall=1, no new grant is issued and ptr is frozen. A grant already registered still completes its single wr_en cycle.
- Simultaneous requests: resolved strictly by ptr order. Requests arriving together with a grant are considered next cycle.
- Request dropped before grant: not granted, no state change.
- Reset mid-ISSUE: wr_en forced to 0 on the reset edge; the write is lost. The requester must re-request.
- wr_sel bit widths pass through unchanged; no arithmetic on indices.

Optional Feature:
- Macro: R0_WRITE_BLOCK_EN.
- Defined:
  - A granted request with req_idx==0 still receives gnt (the requester is released).
  - wr_en is held 0 for that cycle, so register R0 is never written.
  - An extra output r0_drop (1 bit, reset 0) pulses high for that cycle.
- Undefined: R0 is writable like any register, and r0_drop does not exist.

Test Plan:
- Reset: assert clear 2 cycles with req=3'b111 → gnt=0, wr_en=0, wr_sel=0, wr_data=0 throughout. After release, first grant goes to requester 0.
- Single request: req=3'b010, idx1=4'd5, data1=32'hDEADBEEF → next cycle gnt=3'b010, wr_en=1, wr_sel=5, wr_data=DEADBEEF. Following cycle wr_en=0.
- Round robin: req=3'b111 held continuously → gnt sequence 001,010,100,001 on consecutive cycles, wr_en high every cycle.
- Stall: req=3'b101 with stall=1 for 3 cycles → no gnt. Drop stall → gnt=001, then gnt=100.
- Reset mid-write: clear asserted on the cycle wr_en=1 → next edge wr_en=0, ptr=0, state IDLE.
- R0 block (with R0_WRITE_BLOCK_EN): req0 with idx=0 → gnt=001, wr_en=0, r0_drop=1. Without the macro → wr_en=1, wr_sel=0.
